// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage.
//   WB_XLEN / WB_NREGS / WB_CNTW : default datapath width, register count,
//                                  scoreboard counter width
//   wb_sel_e  : result select encoding (reserved code behaves as ALU)
//   ld_size_e : load size encoding (both upper codes are full word)
package wb_stage_pkg;

   localparam int WB_XLEN  = 32;
   localparam int WB_NREGS = 16;
   localparam int WB_CNTW  = 2;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_LOAD = 2'b01,
      WB_SEL_PC4  = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      LD_BYTE  = 2'b00,
      LD_HALF  = 2'b01,
      LD_WORD  = 2'b10,
      LD_WORD2 = 2'b11
   } ld_size_e;

endpackage

// File: rtl/wb_stage_ld_align.sv
// Load alignment for the writeback stage (purely combinational).
//   raw  : raw data-memory word
//   off  : byte offset within the word (off[0] is ignored for halfwords)
//   size : ld_size_e encoding
//   sext : sign-extend byte/half results, otherwise zero-extend
//   data : aligned, extended load value
module wb_stage_ld_align
   import wb_stage_pkg::*;
#(
   parameter int XLEN = WB_XLEN
) (
   input  logic [XLEN-1:0] raw,
   input  logic [1:0]      off,
   input  logic [1:0]      size,
   input  logic            sext,
   output logic [XLEN-1:0] data
);

   logic signed [7:0]  b;
   logic signed [15:0] h;

   always_comb begin
      b    = raw[{off, 3'b000} +: 8];
      h    = raw[{off[1], 4'b0000} +: 16];
      data = raw;
      case (ld_size_e'(size))
         LD_BYTE:  data = sext ? XLEN'(b) : XLEN'($unsigned(b));
         LD_HALF:  data = sext ? XLEN'(h) : XLEN'($unsigned(h));
         default:  data = raw;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB latch, result select/alignment, register-file
// write port and a per-register pending-write scoreboard for RAW stalls.
//   clk, rst        : clock, asynchronous active-high reset
//   mem_*           : instruction leaving MEM (valid, we, rd, sel, size,
//                     sext, alu result, raw load word, pc+4)
//   wb_stall, flush : hold the latch / kill the MEM instruction
//   id_*            : decode issue (we, rd) and source operands (rs, use)
//   EnRW, WN, WD    : register file write port (commits on negedge)
//   raw_stall       : decode must stall on an in-flight write
//   sb_overflow     : sticky, issue hit a saturated counter
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN  = WB_XLEN,
   parameter int NREGS = WB_NREGS,
   parameter int CNTW  = WB_CNTW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid,
   input  logic                     mem_we,
   input  logic [$clog2(NREGS)-1:0] mem_rd,
   input  logic [1:0]               mem_sel,
   input  logic [1:0]               mem_size,
   input  logic                     mem_sext,
   input  logic [XLEN-1:0]          mem_alu,
   input  logic [XLEN-1:0]          mem_ld,
   input  logic [XLEN-1:0]          mem_pc4,
   input  logic                     wb_stall,
   input  logic                     flush,
   input  logic                     id_issue,
   input  logic                     id_we,
   input  logic [$clog2(NREGS)-1:0] id_rd,
   input  logic [$clog2(NREGS)-1:0] id_rs1,
   input  logic [$clog2(NREGS)-1:0] id_rs2,
   input  logic                     id_use1,
   input  logic                     id_use2,
   output logic                     EnRW,
   output logic [$clog2(NREGS)-1:0] WN,
   output logic [XLEN-1:0]          WD,
   output logic                     raw_stall,
   output logic                     sb_overflow
);

   localparam int              RW      = $clog2(NREGS);
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   // Saturating up/down step; simultaneous up and down cancel.
   function automatic logic [CNTW-1:0] sb_step(input logic [CNTW-1:0] c,
                                               input logic up, input logic dn);
      if (up && !dn) return (c == CNT_MAX) ? c : c + 1'b1;
      if (dn && !up) return (c == '0) ? c : c - 1'b1;
      return c;
   endfunction

   // A sole pending write that retires this cycle is seen by decode through
   // the negedge commit, so it does not count as busy.
   function automatic logic busy(input logic [RW-1:0] r, input logic [CNTW-1:0] c,
                                 input logic en, input logic [RW-1:0] wn);
      return (r != '0) && (c != '0) && !((c == CNTW'(1)) && en && (wn == r));
   endfunction

   logic            vld_p0, we_p0, sext_p0;
   logic [RW-1:0]   rd_p0;
   logic [1:0]      sel_p0, size_p0;
   logic [XLEN-1:0] alu_p0, ld_p0, pc4_p0, ld_data;
   logic [CNTW-1:0] cnt     [NREGS];
   logic [CNTW-1:0] cnt_nxt [NREGS];
   logic            inc, ovf_set;

   // ---- MEM -> WB latch (flush wins over stall) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         we_p0   <= 1'b0;
         rd_p0   <= '0;
         sel_p0  <= '0;
         size_p0 <= '0;
         sext_p0 <= 1'b0;
         alu_p0  <= '0;
         ld_p0   <= '0;
         pc4_p0  <= '0;
      end else if (flush || !wb_stall) begin
         vld_p0  <= mem_valid && !flush;
         we_p0   <= mem_we;
         rd_p0   <= mem_rd;
         sel_p0  <= mem_sel;
         size_p0 <= mem_size;
         sext_p0 <= mem_sext;
         alu_p0  <= mem_alu;
         ld_p0   <= mem_ld;
         pc4_p0  <= mem_pc4;
      end
   end

   // ---- WB: result select and register file write port ----
   wb_stage_ld_align #(.XLEN(XLEN)) u_ld_align (
      .raw  (ld_p0),
      .off  (alu_p0[1:0]),
      .size (size_p0),
      .sext (sext_p0),
      .data (ld_data)
   );

   always_comb begin
      case (wb_sel_e'(sel_p0))
         WB_SEL_LOAD: WD = ld_data;
         WB_SEL_PC4:  WD = pc4_p0;
         default:     WD = alu_p0;
      endcase
   end

   assign EnRW = vld_p0 && we_p0 && (rd_p0 != '0) && !wb_stall;
   assign WN   = rd_p0;

   // ---- Scoreboard: pending-write counters ----
   assign inc = id_issue && id_we && (id_rd != '0) && !flush;

   always_comb begin
      ovf_set = 1'b0;
      for (int i = 0; i < NREGS; i++) cnt_nxt[i] = '0;
      if (flush) begin
         // Only a stalled, writing WB instruction survives as pending.
         if (vld_p0 && we_p0 && wb_stall && (rd_p0 != '0)) cnt_nxt[rd_p0] = CNTW'(1);
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            cnt_nxt[i] = sb_step(cnt[i], inc && (id_rd == RW'(i)), EnRW && (WN == RW'(i)));
            if (inc && (id_rd == RW'(i)) && !(EnRW && (WN == RW'(i))) && (cnt[i] == CNT_MAX))
               ovf_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
         sb_overflow <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         sb_overflow <= sb_overflow || ovf_set;
      end
   end

   assign raw_stall = (id_use1 && busy(id_rs1, cnt[id_rs1], EnRW, WN)) ||
                      (id_use2 && busy(id_rs2, cnt[id_rs2], EnRW, WN));

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the stage.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid, mem_we, mem_sext;
   logic [3:0]  mem_rd;
   logic [1:0]  mem_sel, mem_size;
   logic [31:0] mem_alu, mem_ld, mem_pc4;
   logic        wb_stall, flush, id_issue, id_we, id_use1, id_use2;
   logic [3:0]  id_rd, id_rs1, id_rs2;
   logic        EnRW, raw_stall, sb_overflow;
   logic [3:0]  WN;
   logic [31:0] WD;

   int n_chk = 0;
   int n_err = 0;

   // behavioural model state
   bit          m_vld, m_we, m_sext, m_ovf;
   int          m_rd, m_sel, m_size;
   logic [31:0] m_alu, m_ld, m_pc4;
   int          m_cnt [16];

   wb_stage dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_sel(mem_sel),
      .mem_size(mem_size), .mem_sext(mem_sext), .mem_alu(mem_alu), .mem_ld(mem_ld),
      .mem_pc4(mem_pc4), .wb_stall(wb_stall), .flush(flush), .id_issue(id_issue),
      .id_we(id_we), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2), .EnRW(EnRW), .WN(WN), .WD(WD),
      .raw_stall(raw_stall), .sb_overflow(sb_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_wd();
      int          off;
      logic [31:0] v;
      off = int'(m_alu % 4);
      if (m_sel == 1) begin
         if (m_size == 0) begin
            v = (m_ld >> (8 * off)) & 32'hFF;
            if (m_sext && v >= 32'h80) v = v - 32'h100;
         end else if (m_size == 1) begin
            v = (m_ld >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            if (m_sext && v >= 32'h8000) v = v - 32'h10000;
         end else begin
            v = m_ld;
         end
      end else if (m_sel == 2) begin
         v = m_pc4;
      end else begin
         v = m_alu;
      end
      return v;
   endfunction

   function automatic bit m_busy(input int r, input bit en);
      return (r != 0) && (m_cnt[r] > 0) && !(m_cnt[r] == 1 && en && m_rd == r);
   endfunction

   task automatic model_reset();
      m_vld = 0; m_we = 0; m_sext = 0; m_ovf = 0;
      m_rd = 0; m_sel = 0; m_size = 0;
      m_alu = '0; m_ld = '0; m_pc4 = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
   endtask

   task automatic idle();
      mem_valid = 0; mem_we = 0; mem_rd = 0; mem_sel = 0; mem_size = 0; mem_sext = 0;
      mem_alu = '0; mem_ld = '0; mem_pc4 = '0;
      wb_stall = 0; flush = 0; id_issue = 0; id_we = 0; id_rd = 0;
      id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
   endtask

   // Called just after a negedge with inputs applied: check outputs, advance
   // the model across the coming posedge, and return at the next negedge.
   task automatic cycle();
      bit e_en, e_raw;
      int ir, dr;
      #1;
      e_en  = m_vld && m_we && (m_rd != 0) && !wb_stall;
      e_raw = (id_use1 && m_busy(int'(id_rs1), e_en)) || (id_use2 && m_busy(int'(id_rs2), e_en));
      check("enrw", 32'(EnRW), 32'(e_en));
      check("wn", 32'(WN), 32'(m_rd));
      check("wd", WD, ref_wd());
      check("raw_stall", 32'(raw_stall), 32'(e_raw));
      check("sb_overflow", 32'(sb_overflow), 32'(m_ovf));
      if (flush) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         if (m_vld && m_we && wb_stall && m_rd != 0) m_cnt[m_rd] = 1;
      end else begin
         ir = (id_issue && id_we && id_rd != 0) ? int'(id_rd) : -1;
         dr = e_en ? m_rd : -1;
         if (ir != dr) begin
            if (ir > 0) begin
               if (m_cnt[ir] == 3) m_ovf = 1;
               else m_cnt[ir]++;
            end
            if (dr > 0 && m_cnt[dr] > 0) m_cnt[dr]--;
         end
      end
      if (flush || !wb_stall) begin
         m_vld = mem_valid && !flush; m_we = mem_we; m_rd = int'(mem_rd);
         m_sel = int'(mem_sel); m_size = int'(mem_size); m_sext = mem_sext;
         m_alu = mem_alu; m_ld = mem_ld; m_pc4 = mem_pc4;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_load(input string tag, input logic [31:0] alu, input logic [1:0] size,
                          input logic sext, input logic [31:0] exp);
      idle();
      mem_valid = 1; mem_we = 1; mem_rd = 4; mem_sel = 2'b01; mem_size = size;
      mem_sext = sext; mem_alu = alu; mem_ld = 32'h80FF7F01;
      cycle();
      idle();
      #1 check(tag, WD, exp);
      cycle();
   endtask

   initial begin
      idle();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_enrw", 32'(EnRW), 0);
      check("rst_wn", 32'(WN), 0);
      check("rst_wd", WD, 0);
      check("rst_raw", 32'(raw_stall), 0);
      check("rst_ovf", 32'(sb_overflow), 0);
      rst = 0;

      // ALU writeback
      idle();
      mem_valid = 1; mem_we = 1; mem_rd = 3; mem_alu = 32'h0000AABB;
      cycle();
      idle();
      #1;
      check("t1_enrw", 32'(EnRW), 1);
      check("t1_wn", 32'(WN), 3);
      check("t1_wd", WD, 32'h0000AABB);
      cycle();

      // load alignment
      do_load("t2_byte_sext", 32'h1, 2'b00, 1'b1, 32'h0000007F);
      do_load("t2_half_sext", 32'h2, 2'b01, 1'b1, 32'hFFFF80FF);
      do_load("t2_half_zext", 32'h2, 2'b01, 1'b0, 32'h000080FF);

      // R0 suppression
      idle();
      mem_valid = 1; mem_we = 1; mem_rd = 0; mem_alu = 32'h5;
      id_issue = 1; id_we = 1; id_rd = 0;
      cycle();
      idle();
      id_rs1 = 0; id_use1 = 1;
      #1;
      check("t3_enrw_r0", 32'(EnRW), 0);
      check("t3_raw_r0", 32'(raw_stall), 0);
      cycle();

      // RAW hazard on r5 until its retiring cycle
      idle();
      id_issue = 1; id_we = 1; id_rd = 5;
      cycle();
      idle();
      id_rs1 = 5; id_use1 = 1;
      #1 check("t4_raw_pend", 32'(raw_stall), 1);
      cycle();
      idle();
      id_rs1 = 5; id_use1 = 1; mem_valid = 1; mem_we = 1; mem_rd = 5; mem_alu = 32'd123;
      #1 check("t4_raw_inmem", 32'(raw_stall), 1);
      cycle();
      idle();
      id_rs1 = 5; id_use1 = 1;
      #1;
      check("t4_enrw", 32'(EnRW), 1);
      check("t4_raw_retire", 32'(raw_stall), 0);
      cycle();

      // saturation and simultaneous issue/retire on r7
      for (int i = 0; i < 4; i++) begin
         idle();
         id_issue = 1; id_we = 1; id_rd = 7;
         cycle();
      end
      idle();
      #1 check("t5_ovf", 32'(sb_overflow), 1);
      mem_valid = 1; mem_we = 1; mem_rd = 7;
      cycle();
      idle();
      id_issue = 1; id_we = 1; id_rd = 7;
      cycle();
      for (int i = 0; i < 4; i++) begin
         idle();
         mem_valid = 1; mem_we = 1; mem_rd = 7; id_rs2 = 7; id_use2 = 1;
         if (i == 0) #1 check("t5_raw_held", 32'(raw_stall), 1);
         cycle();
      end
      idle();
      id_rs2 = 7; id_use2 = 1;
      #1 check("t5_drained", 32'(raw_stall), 0);
      cycle();

      // stall, then flush while stalled
      idle();
      mem_valid = 1; mem_we = 1; mem_rd = 9; mem_alu = 32'hDEAD0009;
      id_issue = 1; id_we = 1; id_rd = 2;
      cycle();
      for (int i = 0; i < 2; i++) begin
         idle();
         wb_stall = 1; mem_valid = 1; mem_we = 1; mem_rd = 11; mem_alu = $urandom;
         #1;
         check("t6_stall_enrw", 32'(EnRW), 0);
         check("t6_stall_wn", 32'(WN), 9);
         check("t6_stall_wd", WD, 32'hDEAD0009);
         cycle();
      end
      idle();
      wb_stall = 1; flush = 1; id_issue = 1; id_we = 1; id_rd = 3;
      cycle();
      idle();
      id_rs1 = 9; id_use1 = 1;
      #1 check("t6_flush_keep", 32'(raw_stall), 1);
      id_use1 = 0; id_rs2 = 2; id_use2 = 1;
      #1 check("t6_flush_clear", 32'(raw_stall), 0);
      id_rs2 = 3;
      #1 check("t6_flush_noissue", 32'(raw_stall), 0);
      cycle();

      // asynchronous reset in the middle of a retire
      idle();
      mem_valid = 1; mem_we = 1; mem_rd = 6; mem_alu = 32'd77;
      id_issue = 1; id_we = 1; id_rd = 6;
      cycle();
      idle();
      id_rs1 = 9; id_use1 = 1;
      #1 check("t6_pre_rst_enrw", 32'(EnRW), 1);
      #1 rst = 1;
      #1;
      check("t6_rst_enrw", 32'(EnRW), 0);
      check("t6_rst_wn", 32'(WN), 0);
      check("t6_rst_wd", WD, 0);
      check("t6_rst_raw", 32'(raw_stall), 0);
      check("t6_rst_ovf", 32'(sb_overflow), 0);
      model_reset();
      @(negedge clk);
      rst = 0;

      // random traffic
      for (int n = 0; n < 600; n++) begin
         mem_valid = ($urandom_range(0, 3) != 0);
         mem_we    = ($urandom_range(0, 4) != 0);
         mem_rd    = 4'($urandom_range(0, 7));
         mem_sel   = 2'($urandom);
         mem_size  = 2'($urandom);
         mem_sext  = 1'($urandom);
         mem_alu   = $urandom;
         mem_ld    = $urandom;
         mem_pc4   = $urandom;
         wb_stall  = ($urandom_range(0, 3) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         id_issue  = 1'($urandom);
         id_we     = ($urandom_range(0, 4) != 0);
         id_rd     = 4'($urandom_range(0, 7));
         id_rs1    = 4'($urandom_range(0, 7));
         id_rs2    = 4'($urandom_range(0, 7));
         id_use1   = 1'($urandom);
         id_use2   = 1'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
